// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM pixel memory slave.
// Image-window addresses match the pixel-processing master's map.
package avmm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  localparam logic [31:0] FILL_WORD = 32'hDEAD_BEEF;

  localparam logic [31:0] IMG_TOP_ADDR = 32'h0800_0000;
  localparam logic [31:0] IMG_MID_ADDR = 32'h0800_0800;
  localparam logic [31:0] IMG_BOT_ADDR = 32'h0800_1000;
  localparam logic [31:0] IMG_OUT_ADDR = 32'h0850_0000;

  localparam int BYTE_STEP = 4;

endpackage

// File: rtl/avmm_read_pipe.sv
// Fixed-latency read return pipe of {valid, data} stages.
// Reset drops every in-flight read.
module avmm_read_pipe #(
  parameter int LAT = 2,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [LAT-1:0] r_v;
  logic [DW-1:0]  r_d [LAT];

  // shift valid/data one stage per cycle, clear synchronously
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v <= '0;
      for (int i = 0; i < LAT; i++) r_d[i] <= '0;
    end else begin
      r_v[0] <= i_valid;
      r_d[0] <= i_data;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end

  assign o_valid = r_v[LAT-1];
  assign o_data  = r_d[LAT-1];

endmodule

// File: rtl/avmm_pixel_mem_slave.sv
// Avalon-MM pipelined slave modelling the image window as word memory.
// Programmable waitrequest stalls and fixed-latency readdatavalid.
module avmm_pixel_mem_slave
  import avmm_pkg::*;
#(
  parameter int ADDRESSWIDTH   = 26,
  parameter int DATAWIDTH      = 32,
  parameter int MEM_WORDS_LOG2 = 12,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = 26'h000_0000,
  parameter int WAIT_CYCLES    = 1,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDRESSWIDTH-1:0]   slave_address,
  input  logic [DATAWIDTH-1:0]      slave_writedata,
  input  logic [DATAWIDTH/8-1:0]    slave_byteenable,
  input  logic                      slave_write,
  input  logic                      slave_read,
  output logic                      slave_waitrequest,
  output logic [DATAWIDTH-1:0]      slave_readdata,
  output logic                      slave_readdatavalid,
  output logic                      range_err,
  output logic                      proto_err,
  output logic [15:0]               rd_count,
  output logic [15:0]               wr_count
);

  localparam int BE    = DATAWIDTH / 8;
  localparam int DEPTH = 2 ** MEM_WORDS_LOG2;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  stall_state_t r_state;
  stall_state_t w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         w_stall;

  logic w_cmd;
  logic w_acc;
  logic w_wr_en;
  logic w_rd_en;

  logic [ADDRESSWIDTH-1:0]   w_off;
  logic                      w_in;
  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic [DATAWIDTH-1:0]      w_rd_data;

  logic [DATAWIDTH-1:0] r_mem [DEPTH];

  logic        r_range;
  logic        r_proto;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  assign w_cmd = slave_read | slave_write;

  // stall state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // stall next-state and waitrequest decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cmd && WAIT_C != 4'd0) begin
          w_stall     = 1'b1;
          w_state_nxt = STALL;
          w_cnt_nxt   = 4'd1;
        end
      end
      STALL: begin
        if (!w_cmd) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WAIT_C) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign slave_waitrequest = ~reset_n | w_stall;
  assign w_acc = w_cmd & ~slave_waitrequest;

  assign w_off = slave_address - BASE_ADDR;
  assign w_idx = w_off[MEM_WORDS_LOG2+1:2];
  assign w_in  = (slave_address >= BASE_ADDR)
               & ((w_off >> (MEM_WORDS_LOG2 + 2)) == '0)
               & (slave_address[1:0] == 2'b00);

  // a write wins over a simultaneous read
  assign w_wr_en = w_acc & slave_write & w_in;
  assign w_rd_en = w_acc & slave_read & ~slave_write;

  // byte-lane memory writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < BE; b++) begin
        if (slave_byteenable[b])
          r_mem[w_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
      end
    end
  end

  assign w_rd_data = w_in ? r_mem[w_idx] : DATAWIDTH'(FILL_WORD);

  avmm_read_pipe #(
    .LAT (READ_LATENCY),
    .DW  (DATAWIDTH)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_rd_en),
    .i_data  (w_rd_data),
    .o_valid (slave_readdatavalid),
    .o_data  (slave_readdata)
  );

  // accepted-command counters and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_range  <= 1'b0;
      r_proto  <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_acc & slave_write) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_acc & ~w_in) r_range <= 1'b1;
      if (w_acc & slave_write & slave_read) r_proto <= 1'b1;
    end
  end

  assign range_err = r_range;
  assign proto_err = r_proto;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_avmm_pixel_mem_slave.sv
// Bench for avmm_pixel_mem_slave: two instances (stalling / zero-wait),
// directed steps plus random traffic against a word-array model.
module tb_avmm_pixel_mem_slave;

  localparam logic [31:0] FILL = 32'hDEAD_BEEF;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk;
  logic reset_n;

  logic [25:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        wr    [2];
  logic        rd    [2];
  logic        wreq  [2];
  logic [31:0] rdata [2];
  logic        rdv   [2];
  logic        rerr  [2];
  logic        perr  [2];
  logic [15:0] rdc   [2];
  logic [15:0] wrc   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mm [2][4096];
  logic [15:0] ewr [2];
  logic [15:0] erd [2];
  logic        erng [2];
  logic        eprt [2];
  logic [31:0] last_rd [2];
  exp_t qa[$];
  exp_t qb[$];

  avmm_pixel_mem_slave #(
    .ADDRESSWIDTH(26), .DATAWIDTH(32), .MEM_WORDS_LOG2(12),
    .BASE_ADDR(26'h000_0000), .WAIT_CYCLES(1), .READ_LATENCY(LAT)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .slave_address(addr[0]), .slave_writedata(wdata[0]),
    .slave_byteenable(be[0]), .slave_write(wr[0]), .slave_read(rd[0]),
    .slave_waitrequest(wreq[0]), .slave_readdata(rdata[0]),
    .slave_readdatavalid(rdv[0]), .range_err(rerr[0]),
    .proto_err(perr[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
  );

  avmm_pixel_mem_slave #(
    .ADDRESSWIDTH(26), .DATAWIDTH(32), .MEM_WORDS_LOG2(12),
    .BASE_ADDR(26'h000_0100), .WAIT_CYCLES(0), .READ_LATENCY(LAT)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .slave_address(addr[1]), .slave_writedata(wdata[1]),
    .slave_byteenable(be[1]), .slave_write(wr[1]), .slave_read(rd[1]),
    .slave_waitrequest(wreq[1]), .slave_readdata(rdata[1]),
    .slave_readdatavalid(rdv[1]), .range_err(rerr[1]),
    .proto_err(perr[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waitc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int unsigned base(input int d);
    return (d == 0) ? 32'h0 : 32'h100;
  endfunction

  function automatic bit in_rng(input int d, input logic [25:0] a);
    int unsigned ua;
    ua = 32'(a);
    if (ua < base(d)) return 1'b0;
    if ((ua % 4) != 0) return 1'b0;
    return ((ua - base(d)) / 4) < 4096;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? qa.size() : qb.size();
    if (rdv[d] === 1'b1) begin
      if (n == 0) begin
        chk($sformatf("rdv_unexpected%0d", d), 32'(rdv[d]), 32'd0);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        last_rd[d] = rdata[d];
        chk($sformatf("rdata%0d", d), rdata[d], e.d);
        chk($sformatf("rdv_cycle%0d", d), 32'(cyc), 32'(e.due));
      end
    end else if (n > 0) begin
      e = (d == 0) ? qa[0] : qb[0];
      if (e.due <= cyc) begin
        chk($sformatf("rdv_missing%0d", d), 32'(rdv[d]), 32'd1);
        if (d == 0) void'(qa.pop_front());
        else void'(qb.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon(0);
    mon(1);
  endtask

  task automatic cmd(input int d, input bit r, input bit w,
                     input logic [25:0] a, input logic [31:0] dat,
                     input logic [3:0] b);
    int   waits;
    int   idx;
    bit   inr;
    exp_t e;
    rd[d] = r;
    wr[d] = w;
    addr[d] = a;
    wdata[d] = dat;
    be[d] = b;
    waits = 0;
    #1;
    while (wreq[d] !== 1'b0 && waits < 40) begin
      tick();
      #1;
      waits++;
    end
    chk($sformatf("waits%0d", d), 32'(waits), 32'(waitc(d)));
    inr = in_rng(d, a);
    idx = inr ? int'((32'(a) - base(d)) / 4) : 0;
    if (w) begin
      ewr[d]++;
      if (inr) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mm[d][idx][8*k +: 8] = dat[8*k +: 8];
      end else begin
        erng[d] = 1'b1;
      end
      if (r) eprt[d] = 1'b1;
    end else if (r) begin
      erd[d]++;
      if (!inr) erng[d] = 1'b1;
      e.d = inr ? mm[d][idx] : FILL;
      e.due = cyc + LAT;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    tick();
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic check_regs(input int d);
    chk($sformatf("wr_count%0d", d), 32'(wrc[d]), 32'(ewr[d]));
    chk($sformatf("rd_count%0d", d), 32'(rdc[d]), 32'(erd[d]));
    chk($sformatf("range_err%0d", d), 32'(rerr[d]), 32'(erng[d]));
    chk($sformatf("proto_err%0d", d), 32'(perr[d]), 32'(eprt[d]));
  endtask

  task automatic drain();
    repeat (LAT + 3) tick();
  endtask

  task automatic enter_reset();
    reset_n = 1'b0;
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      ewr[d] = '0;
      erd[d] = '0;
      erng[d] = 1'b0;
      eprt[d] = 1'b0;
    end
  endtask

  task automatic check_in_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_wreq%0d", d), 32'(wreq[d]), 32'd1);
      chk($sformatf("rst_rdv%0d", d), 32'(rdv[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
      check_regs(d);
    end
  endtask

  initial begin
    logic [25:0] a;
    int          d;
    int          op;
    int          sel;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; be[i] = '0;
      wr[i] = 1'b0; rd[i] = 1'b0; last_rd[i] = '0;
    end
    enter_reset();
    repeat (3) tick();
    check_in_reset();
    reset_n = 1'b1;
    tick();

    // basic write then read with one stall cycle each
    cmd(0, 0, 1, 26'd8, 32'h1122_3344, 4'hF);
    cmd(0, 1, 0, 26'd8, 32'h0, 4'hF);
    drain();
    chk("raw_read", last_rd[0], 32'h1122_3344);
    check_regs(0);

    // byte-enable merge
    cmd(0, 0, 1, 26'h10, 32'h0, 4'hF);
    cmd(0, 0, 1, 26'h10, 32'hAABB_CCDD, 4'b0101);
    cmd(0, 1, 0, 26'h10, 32'h0, 4'hF);
    drain();
    chk("be_merge", last_rd[0], 32'h00BB_00DD);

    // zero-wait instance: preload then back-to-back reads
    for (int i = 0; i < 4; i++)
      cmd(1, 0, 1, 26'(base(1) + 4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 4; i++)
      cmd(1, 1, 0, 26'(base(1) + 4 * i), 32'h0, 4'hF);
    drain();
    chk("b2b_last", last_rd[1], 32'd3);
    check_regs(1);

    // out-of-range and misaligned accesses
    chk("range_pre", 32'(rerr[0]), 32'd0);
    cmd(0, 1, 0, 26'd2, 32'h0, 4'hF);
    drain();
    chk("misalign_fill", last_rd[0], FILL);
    cmd(0, 1, 0, 26'd16384, 32'h0, 4'hF);
    drain();
    chk("beyond_fill", last_rd[0], FILL);
    cmd(0, 0, 1, 26'h12, 32'hFFFF_FFFF, 4'hF);
    cmd(0, 1, 0, 26'h10, 32'h0, 4'hF);
    drain();
    chk("dropped_wr", last_rd[0], 32'h00BB_00DD);
    check_regs(0);
    cmd(1, 1, 0, 26'h0FC, 32'h0, 4'hF);
    drain();
    chk("below_base", last_rd[1], FILL);
    check_regs(1);

    // simultaneous read and write
    enter_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    cmd(0, 1, 1, 26'd20, 32'h5, 4'hF);
    drain();
    check_regs(0);
    cmd(0, 1, 0, 26'd20, 32'h0, 4'hF);
    drain();
    chk("proto_word", last_rd[0], 32'h5);

    // reset one cycle after a read is accepted
    last_rd[0] = '0;
    cmd(0, 1, 0, 26'd8, 32'h0, 4'hF);
    enter_reset();
    rd[0] = 1'b1;
    repeat (3) tick();
    #1;
    check_in_reset();
    rd[0] = 1'b0;
    reset_n = 1'b1;
    drain();
    chk("reset_discard", last_rd[0], 32'h0);
    cmd(0, 1, 0, 26'd8, 32'h0, 4'hF);
    drain();
    chk("post_reset", last_rd[0], 32'h1122_3344);

    // random traffic over both instances
    for (int i = 0; i < 16; i++) begin
      cmd(0, 0, 1, 26'(4 * i), $urandom, 4'hF);
      cmd(1, 0, 1, 26'(base(1) + 4 * i), $urandom, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)
        a = 26'(base(d) + 4 * $urandom_range(0, 15));
      else if (sel == 7)
        a = 26'(base(d) + 4 * $urandom_range(0, 15)
                + $urandom_range(1, 3));
      else if (sel == 8 && d == 1)
        a = 26'(base(d) - 4 * $urandom_range(1, 60));
      else
        a = 26'(base(d) + 16384 + 4 * $urandom_range(0, 100000));
      op = int'($urandom_range(0, 7));
      cmd(d, op <= 3 || op == 7, op >= 4, a, $urandom,
          4'($urandom_range(0, 15)));
    end
    drain();
    check_regs(0);
    check_regs(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
